// File: rtl/bram_read_streamer.sv
// bram_read_streamer: read-side master for the dual-port BRAM wrapper.
// Issues one single-word read at a time from consecutive addresses, buffers the
// returned words in a small FIFO and presents them as a valid/ready stream with last.
// Optional WAIT-state watchdog: define BRAM_READ_STREAMER_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transfer; waits for start
// S_ISSUE | ready to issue next read once FIFO has room and write port idle
// S_WAIT  | one read outstanding; waits for rd_valid (or watchdog)
// S_DRAIN | all words read; waits for the stream to empty the FIFO
module bram_read_streamer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  wr_active,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  start_ok, can_issue, push, pop, timeout, drain_done, last_word;

  assign start_ok   = (state == S_IDLE) && start;
  assign can_issue  = (count < FIFO_FULL) && !wr_active;
  assign push       = (state == S_WAIT) && rd_valid;
  assign pop        = m_tvalid && m_tready;
  assign last_word  = (remaining == LEN_WIDTH'(1));
  // FIFO empties on this edge or already has; lets done follow the last beat directly
  assign drain_done = (count == '0) || ((count == (PTR_W+1)'(1)) && pop);

  assign busy     = (state != S_IDLE);
  assign rd_addr  = cur_addr;
  assign m_tvalid = (count != '0);
  // gate head entry so stale FIFO contents never show while the stream is idle
  assign m_tdata  = m_tvalid ? fifo_data[rd_ptr] : '0;
  assign m_tlast  = m_tvalid ? fifo_last[rd_ptr] : 1'b0;

`ifdef BRAM_READ_STREAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout = (state == S_WAIT) && !rd_valid &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // watchdog: counts consecutive WAIT cycles without a returned word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         wd_cnt <= '0;
    else if ((state == S_WAIT) && !rd_valid && !timeout) wd_cnt <= wd_cnt + WD_W'(1);
    else                                              wd_cnt <= '0;
  end

  // sticky timeout flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          err <= 1'b0;
    else if (start_ok) err <= 1'b0;
    else if (timeout)  err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  // watchdog not built: err is constant low (comparison keeps the parameter referenced)
  assign err = (TIMEOUT_CYCLES < 0);
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state and read-issue decode
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      S_IDLE:  if (start && (length != '0)) state_nxt = S_ISSUE;
      S_ISSUE: if (can_issue) begin
                 rd_en     = 1'b1;
                 state_nxt = S_WAIT;
               end
      S_WAIT:  if (rd_valid)     state_nxt = last_word ? S_DRAIN : S_ISSUE;
               else if (timeout) state_nxt = S_IDLE;
      S_DRAIN: if (drain_done)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // transfer bookkeeping, done pulse and FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        cur_addr  <= base_addr;
        remaining <= length;
        // zero-length request completes without ever leaving IDLE
        if (length == '0) done <= 1'b1;
      end
      if (push) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
      if ((state == S_DRAIN) && drain_done) done <= 1'b1;
      if (timeout) begin
        done   <= 1'b1;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + (PTR_W+1)'(1);
        else if (pop && !push) count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since m_tvalid gates them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_last[wr_ptr] <= last_word;
    end
  end

endmodule

// File: tb/tb_bram_read_streamer.sv
// tb_bram_read_streamer: randomized and directed checks of bram_read_streamer
// against a queue-based transfer model and a behavioural BRAM responder.
module tb_bram_read_streamer;
  localparam int AW = 16, DW = 32, LW = 16, DEPTH = 4, TO = 16;

  logic clk = 0, rst = 0, start = 0, wr_active = 0, rd_valid = 0, m_tready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic [DW-1:0] rd_data = '0;
  logic busy, done, err, rd_en, m_tvalid, m_tlast;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] m_tdata;

  always #5 clk = ~clk;

  bram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                       .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .wr_active(wr_active), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast));

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;

  int n_chk = 0, n_fail = 0;
  int lat = 2, ready_mode = 1, wr_mode = 0;
  bit suppress = 0, expect_abort = 0, xfer_active = 0, outstanding = 0;
  beat_t exp_beats[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] seen_data[$];
  logic seen_last[$];
  logic [AW-1:0] seen_addr[$];
  int rd_cnt = 0, done_cnt = 0, issued = 0, popped = 0;
  logic prev_stall = 0, prev_last = 0;
  logic [DW-1:0] prev_data = '0;

  // BRAM contents: each word is {address, ~address}
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // consumer-ready and write-port activity drivers
  initial begin
    forever begin
      @(posedge clk); #2;
      m_tready  = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      wr_active = (wr_mode == 2) ? ($urandom_range(0, 3) == 0) : (wr_mode == 1);
    end
  end

  // behavioural BRAM wrapper: one word back lat cycles after each rd_en
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (rst && rd_en && !suppress) begin
        a = rd_addr;
        repeat (lat) @(posedge clk);
        #1 rd_valid = 1'b1; rd_data = mem_word(a);
        @(posedge clk);
        #1 rd_valid = 1'b0; rd_data = '0;
      end
    end
  end

  // per-cycle compare against the transfer model
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        seen_addr.push_back(rd_addr);
        chk("rd_en_expected", 64'(exp_addr.size() != 0), 1);
        chk("rd_en_one_outstanding", 64'(outstanding), 0);
        chk("rd_en_write_idle", 64'(wr_active), 0);
        chk("rd_en_fifo_room", 64'((issued - popped) < DEPTH), 1);
        if (exp_addr.size() != 0) chk("rd_addr", 64'(rd_addr), 64'(exp_addr.pop_front()));
        issued++;
        outstanding = 1;
      end
      if (rd_valid) outstanding = 0;
      if (prev_stall) begin
        chk("hold_valid", 64'(m_tvalid), 1);
        chk("hold_data", 64'(m_tdata), 64'(prev_data));
        chk("hold_last", 64'(m_tlast), 64'(prev_last));
      end
      if (m_tvalid) begin
        chk("tvalid_has_word", 64'(issued > popped), 1);
        if (m_tready) begin
          seen_data.push_back(m_tdata);
          seen_last.push_back(m_tlast);
          chk("beat_expected", 64'(exp_beats.size() != 0), 1);
          if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            chk("m_tdata", 64'(m_tdata), 64'(b.d));
            chk("m_tlast", 64'(m_tlast), 64'(b.l));
          end
          popped++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (done) begin
        done_cnt++;
        chk("done_in_transfer", 64'(xfer_active), 1);
        chk("done_not_busy", 64'(busy), 0);
        chk("done_tvalid_low", 64'(m_tvalid), 0);
        if (expect_abort) begin
          chk("abort_err", 64'(err), 1);
          exp_beats.delete();
          exp_addr.delete();
          outstanding = 0;
        end else begin
          chk("done_beats_left", 64'(exp_beats.size()), 0);
          chk("done_reads_left", 64'(exp_addr.size()), 0);
          chk("done_err", 64'(err), 0);
        end
        xfer_active = 0;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    int g = 0;
    beat_t bt;
    while ((xfer_active || busy) && g < 2000) begin @(posedge clk); #1; g++; end
    chk("start_idle_wait", 64'(g < 2000), 1);
    for (int i = 0; i < int'(l); i++) begin
      exp_addr.push_back(b + AW'(i));
      bt.d = mem_word(b + AW'(i));
      bt.l = (i == int'(l) - 1);
      exp_beats.push_back(bt);
    end
    issued = 0; popped = 0; xfer_active = 1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (xfer_active && g < 2000) begin @(posedge clk); #1; g++; end
    chk("done_timeout", 64'(xfer_active), 0);
  endtask

  task automatic clear_logs();
    seen_data.delete(); seen_last.delete(); seen_addr.delete();
  endtask

  initial begin
    int r0, d0, g;
    logic [3:0] lasts;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);     chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);       chk("rst_rd_en", 64'(rd_en), 0);
    chk("rst_tvalid", 64'(m_tvalid), 0); chk("rst_tlast", 64'(m_tlast), 0);
    chk("rst_rd_addr", 64'(rd_addr), 0); chk("rst_tdata", 64'(m_tdata), 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // basic 4-word transfer
    clear_logs(); d0 = done_cnt;
    do_start(16'h0010, 4); wait_done();
    chk("t1_done_count", 64'(done_cnt - d0), 1);
    chk("t1_beats", 64'(seen_data.size()), 4);
    chk("t1_reads", 64'(seen_addr.size()), 4);
    if (seen_data.size() == 4 && seen_addr.size() == 4) begin
      chk("t1_word0", 64'(seen_data[0]), 64'h0010FFEF);
      chk("t1_word3", 64'(seen_data[3]), 64'h0013FFEC);
      chk("t1_addr3", 64'(seen_addr[3]), 64'h0013);
      lasts = {seen_last[0], seen_last[1], seen_last[2], seen_last[3]};
      chk("t1_last_pattern", 64'(lasts), 64'b0001);
    end

    // zero-length transfer
    r0 = rd_cnt; d0 = done_cnt;
    do_start(16'h0020, 0);
    @(negedge clk);
    chk("t2_done_next_cycle", 64'(done), 1);
    chk("t2_tvalid", 64'(m_tvalid), 0);
    @(posedge clk); #1;
    chk("t2_no_reads", 64'(rd_cnt - r0), 0);
    chk("t2_done_count", 64'(done_cnt - d0), 1);

    // back-pressure: only FIFO_DEPTH reads while consumer stalls
    clear_logs(); ready_mode = 0; r0 = rd_cnt;
    do_start(16'h0100, 8);
    repeat (40) @(posedge clk); #1;
    chk("t3_reads_while_stalled", 64'(rd_cnt - r0), DEPTH);
    chk("t3_busy_while_stalled", 64'(busy), 1);
    ready_mode = 1;
    wait_done();
    chk("t3_beats", 64'(seen_data.size()), 8);

    // address wrap
    clear_logs();
    do_start(16'hFFFE, 3); wait_done();
    chk("t4_reads", 64'(seen_addr.size()), 3);
    if (seen_addr.size() == 3 && seen_data.size() == 3) begin
      chk("t4_addr_seq", 64'({seen_addr[0], seen_addr[1], seen_addr[2]}), 64'hFFFE_FFFF_0000);
      chk("t4_word2", 64'(seen_data[2]), 64'h0000FFFF);
    end

    // write port busy blocks issue
    wr_mode = 1; @(posedge clk); #1;
    r0 = rd_cnt;
    do_start(16'h0200, 2);
    repeat (10) @(posedge clk); #1;
    chk("t5_no_read_while_wr", 64'(rd_cnt - r0), 0);
    wr_mode = 0;
    @(negedge clk);
    chk("t5_issue_after_wr", 64'(rd_en), 1);
    wait_done();

    // reset in the middle of WAIT
    lat = 20; r0 = rd_cnt;
    do_start(16'h0300, 4);
    g = 0;
    while (rd_cnt == r0 && g < 50) begin @(posedge clk); #1; g++; end
    chk("t6_first_read", 64'(rd_cnt - r0), 1);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 0);   chk("t6_done", 64'(done), 0);
    chk("t6_err", 64'(err), 0);     chk("t6_rd_en", 64'(rd_en), 0);
    chk("t6_tvalid", 64'(m_tvalid), 0); chk("t6_tlast", 64'(m_tlast), 0);
    chk("t6_rd_addr", 64'(rd_addr), 0); chk("t6_tdata", 64'(m_tdata), 0);
    exp_beats.delete(); exp_addr.delete(); xfer_active = 0;
    repeat (25) @(posedge clk); #1 rst = 1'b1; lat = 2;
    @(posedge clk); #1;
    clear_logs();
    do_start(16'h0040, 3); wait_done();
    chk("t6_after_reset_beats", 64'(seen_data.size()), 3);
    if (seen_data.size() == 3) chk("t6_after_reset_word0", 64'(seen_data[0]), 64'h0040FFBF);

`ifdef BRAM_READ_STREAMER_TIMEOUT_EN
    // watchdog abort when the BRAM never answers
    suppress = 1; expect_abort = 1;
    do_start(16'h0400, 3);
    g = 0;
    do begin @(negedge clk); g++; end while (!rd_en && g < 50);
    repeat (TO) @(negedge clk);
    chk("t7_err_not_early", 64'(err), 0);
    chk("t7_done_not_early", 64'(done), 0);
    @(negedge clk);
    chk("t7_err", 64'(err), 1);
    chk("t7_done", 64'(done), 1);
    chk("t7_tvalid", 64'(m_tvalid), 0);
    @(posedge clk); #1 expect_abort = 0; suppress = 0;
    do_start(16'h0500, 2);
    @(negedge clk);
    chk("t7_err_cleared", 64'(err), 0);
    wait_done();
`endif

    // randomized transfers with random back-pressure and write activity
    ready_mode = 2; wr_mode = 2;
    for (int it = 0; it < 14; it++) begin
      lat = $urandom_range(1, 3);
      do_start(AW'($urandom), LW'($urandom_range(0, 9)));
      repeat (2) @(posedge clk); #1;
      if (busy) begin
        base_addr = AW'($urandom); length = LW'($urandom_range(1, 5)); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done();
    end
    ready_mode = 1; wr_mode = 0;
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
